// File: rtl/fust_m_issue_if.sv
// fust_m_issue_if: signal bundle between the matrix FUST entry, the issue/completion
// controller, the matrix execution unit and the writeback port.
//   master modport: the environment (dispatch, operand tracking, matrix unit, writeback).
//   slave modport : the fust_m_issue controller.
// Parameter REG_W: matrix register index width.
interface fust_m_issue_if #(
  parameter int unsigned REG_W = 4
);
  logic             fust_valid;
  logic [REG_W-1:0] fust_rs1;
  logic [REG_W-1:0] fust_rs2;
  logic [REG_W-1:0] fust_rd;
  logic             fust_accept;
  logic             rs1_ready;
  logic             rs2_ready;
  logic             flush;
  logic             mu_req;
  logic             mu_gnt;
  logic [REG_W-1:0] mu_rs1;
  logic [REG_W-1:0] mu_rs2;
  logic [REG_W-1:0] mu_rd;
  logic             mu_done;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             wb_ack;
  logic             busy;
  logic             timeout_err;

  modport master (
    output fust_valid, fust_rs1, fust_rs2, fust_rd, rs1_ready, rs2_ready, flush,
           mu_gnt, mu_done, wb_ack,
    input  fust_accept, mu_req, mu_rs1, mu_rs2, mu_rd, wb_valid, wb_rd, busy, timeout_err
  );

  modport slave (
    input  fust_valid, fust_rs1, fust_rs2, fust_rd, rs1_ready, rs2_ready, flush,
           mu_gnt, mu_done, wb_ack,
    output fust_accept, mu_req, mu_rs1, mu_rs2, mu_rd, wb_valid, wb_rd, busy, timeout_err
  );
endinterface

// File: rtl/fust_m_issue.sv
// fust_m_issue: issue and completion controller for the matrix functional unit.
// Latches a dispatched entry, waits for both operands, issues to the matrix unit with a
// req/gnt handshake, waits for mu_done, then requests writeback. busy mirrors occupancy.
// Ports:
//   CLK, nRST : clock (posedge) and asynchronous active-low reset.
//   fif       : fust_m_issue_if.slave (dispatch entry, operand readiness, flush, matrix-unit
//               handshake, writeback handshake, busy, timeout_err).
// Parameters: REG_W (index width), TIMEOUT (watchdog limit in EXEC cycles).
// Optional feature: define FUST_M_ISSUE_TIMEOUT_EN to enable the EXEC watchdog; otherwise
// timeout_err is tied to 0 and EXEC waits indefinitely.
module fust_m_issue #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          CLK,
  input logic          nRST,
  fust_m_issue_if.slave fif
);

  typedef enum logic [2:0] {IDLE, WAIT_OPS, ISSUE, EXEC, WB} state_t;

  state_t           state, next_state;
  logic             squash, next_squash;
  logic [REG_W-1:0] lat_rs1, lat_rs2, lat_rd;
  logic             lat_en;
  logic             tmo_hit;

  // Flush wins over a coincident dispatch, so nothing is latched on a flush cycle.
  assign fif.fust_accept = (state == IDLE) ||
                           ((state == WB) && fif.wb_ack && !fif.flush);
  assign lat_en          = fif.fust_accept && fif.fust_valid && !fif.flush;

  assign fif.mu_req   = (state == ISSUE);
  assign fif.mu_rs1   = lat_rs1;
  assign fif.mu_rs2   = lat_rs2;
  assign fif.mu_rd    = lat_rd;
  assign fif.wb_valid = (state == WB);
  assign fif.wb_rd    = lat_rd;
  assign fif.busy     = (state != IDLE);

`ifdef FUST_M_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] exec_cnt;

  // Held at zero outside EXEC, so it reads 0 in the first EXEC cycle and N-1 in the Nth.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)               exec_cnt <= '0;
    else if (state != EXEC)  exec_cnt <= '0;
    else                     exec_cnt <= exec_cnt + 1'b1;
  end

  assign tmo_hit         = (state == EXEC) && (exec_cnt == CNT_W'(TIMEOUT - 1));
  // A completion on the limit cycle takes priority over the watchdog.
  assign fif.timeout_err = tmo_hit && !fif.mu_done;
`else
  logic unused_timeout;
  assign unused_timeout  = ^TIMEOUT;
  assign tmo_hit         = 1'b0;
  assign fif.timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      squash <= 1'b0;
    end else begin
      state  <= next_state;
      squash <= next_squash;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_rs1 <= '0;
      lat_rs2 <= '0;
      lat_rd  <= '0;
    end else if (lat_en) begin
      lat_rs1 <= fif.fust_rs1;
      lat_rs2 <= fif.fust_rs2;
      lat_rd  <= fif.fust_rd;
    end
  end

  always_comb begin
    next_state  = state;
    next_squash = squash;
    unique case (state)
      IDLE: begin
        next_squash = 1'b0;
        if (lat_en) next_state = WAIT_OPS;
      end
      WAIT_OPS: begin
        if (fif.flush)                              next_state = IDLE;
        else if (fif.rs1_ready && fif.rs2_ready)    next_state = ISSUE;
      end
      ISSUE: begin
        // A grant has happened even if flush coincides; the op must drain through EXEC.
        if (fif.mu_gnt) begin
          next_state  = EXEC;
          next_squash = fif.flush;
        end else if (fif.flush) begin
          next_state  = IDLE;
        end
      end
      EXEC: begin
        if (fif.mu_done) begin
          next_state  = (squash || fif.flush) ? IDLE : WB;
          next_squash = 1'b0;
        end else if (tmo_hit) begin
          next_state  = IDLE;
          next_squash = 1'b0;
        end else if (fif.flush) begin
          next_squash = 1'b1;
        end
      end
      WB: begin
        if (fif.flush)        next_state = IDLE;
        else if (fif.wb_ack)  next_state = lat_en ? WAIT_OPS : IDLE;
      end
      default: begin
        next_state  = IDLE;
        next_squash = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fust_m_issue.sv
// Directed self-checking bench for fust_m_issue. Inputs change 1ns after posedge; registered
// outputs are checked 1ns after posedge, combinational ones after a further 1ns settle.
module tb_fust_m_issue;
  localparam int unsigned REG_W = 4;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  fust_m_issue_if #(.REG_W(REG_W)) fif ();

  fust_m_issue #(.REG_W(REG_W), .TIMEOUT(10)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (fif)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    fif.fust_valid = 1'b0;
    fif.fust_rs1   = '0;
    fif.fust_rs2   = '0;
    fif.fust_rd    = '0;
    fif.rs1_ready  = 1'b1;
    fif.rs2_ready  = 1'b1;
    fif.flush      = 1'b0;
    fif.mu_gnt     = 1'b0;
    fif.mu_done    = 1'b0;
    fif.wb_ack     = 1'b0;
  endtask

  // Dispatch one entry from IDLE and advance to the first EXEC cycle (no stalls).
  task automatic go_exec(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd);
    fif.fust_valid = 1'b1;
    fif.fust_rs1 = rs1; fif.fust_rs2 = rs2; fif.fust_rd = rd;
    step();
    fif.fust_valid = 1'b0;
    step();
    fif.mu_gnt = 1'b1;
    step();
    fif.mu_gnt = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if ({fif.busy, fif.mu_req, fif.wb_valid, fif.timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: busy/mu_req/wb_valid/tmo=%b required 0000",
               {fif.busy, fif.mu_req, fif.wb_valid, fif.timeout_err});
    end
    checks++;
    if ({fif.mu_rs1, fif.mu_rs2, fif.wb_rd} !== 12'h000) begin
      errors++;
      $display("FAIL reset_indices: got %h required 000", {fif.mu_rs1, fif.mu_rs2, fif.wb_rd});
    end
    checks++;
    if (fif.fust_accept !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept: got %b required 1", fif.fust_accept);
    end
    #1 nRST = 1'b1;
    step();
  endtask

  task automatic test_single_op();
    // cycle 0
    fif.fust_valid = 1'b1;
    fif.fust_rs1 = 4'd2; fif.fust_rs2 = 4'd3; fif.fust_rd = 4'd5;
    fif.mu_gnt = 1'b1; fif.wb_ack = 1'b1;
    step(); // cycle 1
    fif.fust_valid = 1'b0;
    checks++;
    if (fif.busy !== 1'b1 || fif.mu_req !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: busy=%b mu_req=%b required busy=1 mu_req=0", fif.busy, fif.mu_req);
    end
    step(); // cycle 2
    checks++;
    if (fif.mu_req !== 1'b1 || {fif.mu_rs1, fif.mu_rs2, fif.mu_rd} !== {4'd2, 4'd3, 4'd5}) begin
      errors++;
      $display("FAIL single_issue: mu_req=%b idx=%h required 1 235", fif.mu_req,
               {fif.mu_rs1, fif.mu_rs2, fif.mu_rd});
    end
    step(); // cycle 3: EXEC
    fif.mu_gnt = 1'b0;
    checks++;
    if (fif.mu_req !== 1'b0 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_exec: mu_req=%b busy=%b required 0 1", fif.mu_req, fif.busy);
    end
    step(); step(); step(); // cycle 6
    fif.mu_done = 1'b1;
    step(); // cycle 7
    fif.mu_done = 1'b0;
    checks++;
    if (fif.wb_valid !== 1'b1 || fif.wb_rd !== 4'd5) begin
      errors++;
      $display("FAIL single_wb: wb_valid=%b wb_rd=%0d required 1 5", fif.wb_valid, fif.wb_rd);
    end
    step(); // cycle 8
    fif.wb_ack = 1'b0;
    checks++;
    if (fif.busy !== 1'b0 || fif.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b wb_valid=%b required 0 0", fif.busy, fif.wb_valid);
    end
  endtask

  task automatic test_operand_stall();
    fif.fust_valid = 1'b1; fif.fust_rd = 4'd11; fif.rs2_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      fif.fust_valid = 1'b0;
      checks++;
      if (fif.mu_req !== 1'b0) begin
        errors++;
        $display("FAIL opstall_c%0d: mu_req=%b required 0", c, fif.mu_req);
      end
    end
    fif.rs2_ready = 1'b1;
    step();
    checks++;
    if (fif.mu_req !== 1'b1) begin
      errors++;
      $display("FAIL opstall_issue: mu_req=%b required 1", fif.mu_req);
    end
    fif.mu_gnt = 1'b1;
    step();
    fif.mu_gnt = 1'b0; fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0; fif.wb_ack = 1'b1;
    checks++;
    if (fif.wb_valid !== 1'b1 || fif.wb_rd !== 4'd11) begin
      errors++;
      $display("FAIL opstall_wb: wb_valid=%b wb_rd=%0d required 1 11", fif.wb_valid, fif.wb_rd);
    end
    step();
    fif.wb_ack = 1'b0;
  endtask

  task automatic test_grant_stall();
    fif.fust_valid = 1'b1;
    fif.fust_rs1 = 4'd1; fif.fust_rs2 = 4'd4; fif.fust_rd = 4'd7;
    step();
    fif.fust_valid = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      // Scramble the entry inputs; the issued indices must come from the latch.
      fif.fust_rs1 = 4'(c + 8); fif.fust_rs2 = 4'(c + 9); fif.fust_rd = 4'(c + 10);
      checks++;
      if (fif.mu_req !== 1'b1 || {fif.mu_rs1, fif.mu_rs2, fif.mu_rd} !== 12'h147) begin
        errors++;
        $display("FAIL gntstall_c%0d: mu_req=%b idx=%h required 1 147", c, fif.mu_req,
                 {fif.mu_rs1, fif.mu_rs2, fif.mu_rd});
      end
      if (c == 3) fif.mu_gnt = 1'b1;
      step();
    end
    fif.mu_gnt = 1'b0;
    checks++;
    if (fif.mu_req !== 1'b0 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL gntstall_exec: mu_req=%b busy=%b required 0 1", fif.mu_req, fif.busy);
    end
    fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0; fif.wb_ack = 1'b1;
    step();
    fif.wb_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    go_exec(4'd1, 4'd2, 4'd6);
    fif.mu_done = 1'b1;
    step(); // WB for rd=6
    fif.mu_done = 1'b0;
    fif.wb_ack = 1'b1; fif.fust_valid = 1'b1;
    fif.fust_rs1 = 4'd3; fif.fust_rs2 = 4'd4; fif.fust_rd = 4'd9;
    #1;
    checks++;
    if (fif.fust_accept !== 1'b1 || fif.wb_rd !== 4'd6) begin
      errors++;
      $display("FAIL b2b_accept: accept=%b wb_rd=%0d required 1 6", fif.fust_accept, fif.wb_rd);
    end
    step(); // WAIT_OPS with new entry
    fif.wb_ack = 1'b0; fif.fust_valid = 1'b0;
    checks++;
    if (fif.busy !== 1'b1 || fif.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b wb_valid=%b required 1 0", fif.busy, fif.wb_valid);
    end
    step();
    fif.mu_gnt = 1'b1;
    step();
    fif.mu_gnt = 1'b0; fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0; fif.wb_ack = 1'b1;
    checks++;
    if (fif.wb_valid !== 1'b1 || fif.wb_rd !== 4'd9) begin
      errors++;
      $display("FAIL b2b_wb: wb_valid=%b wb_rd=%0d required 1 9", fif.wb_valid, fif.wb_rd);
    end
    step();
    fif.wb_ack = 1'b0;
  endtask

  task automatic test_flush();
    // Flush coincident with dispatch in IDLE: nothing latched.
    fif.fust_valid = 1'b1; fif.flush = 1'b1; fif.fust_rd = 4'd13;
    step();
    fif.fust_valid = 1'b0; fif.flush = 1'b0;
    checks++;
    if (fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b required 0", fif.busy);
    end
    // mu_done outside EXEC is ignored.
    fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0;
    checks++;
    if (fif.busy !== 1'b0 || fif.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: busy=%b wb_valid=%b required 0 0", fif.busy, fif.wb_valid);
    end
    // Flush in WAIT_OPS.
    fif.fust_valid = 1'b1; fif.rs1_ready = 1'b0;
    step();
    fif.fust_valid = 1'b0; fif.flush = 1'b1;
    step();
    fif.flush = 1'b0; fif.rs1_ready = 1'b1;
    checks++;
    if (fif.busy !== 1'b0 || fif.mu_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait: busy=%b mu_req=%b required 0 0", fif.busy, fif.mu_req);
    end
    // Flush in EXEC, mu_done two cycles later.
    go_exec(4'd5, 4'd6, 4'd12);
    fif.flush = 1'b1;
    step();
    fif.flush = 1'b0;
    step();
    fif.mu_done = 1'b1;
    checks++;
    if (fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_exec_hold: busy=%b required 1", fif.busy);
    end
    step();
    fif.mu_done = 1'b0; fif.wb_ack = 1'b1;
    checks++;
    if (fif.wb_valid !== 1'b0 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_exec: wb_valid=%b busy=%b required 0 0", fif.wb_valid, fif.busy);
    end
    fif.wb_ack = 1'b0;
    // Flush coincident with grant.
    fif.fust_valid = 1'b1; fif.fust_rd = 4'd14;
    step();
    fif.fust_valid = 1'b0;
    step();
    fif.mu_gnt = 1'b1; fif.flush = 1'b1;
    step();
    fif.mu_gnt = 1'b0; fif.flush = 1'b0;
    checks++;
    if (fif.busy !== 1'b1 || fif.mu_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt_exec: busy=%b mu_req=%b required 1 0", fif.busy, fif.mu_req);
    end
    fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0;
    checks++;
    if (fif.wb_valid !== 1'b0 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt: wb_valid=%b busy=%b required 0 0", fif.wb_valid, fif.busy);
    end
    // Flush in WB: writeback dropped.
    go_exec(4'd0, 4'd1, 4'd2);
    fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0; fif.flush = 1'b1;
    step();
    fif.flush = 1'b0;
    checks++;
    if (fif.wb_valid !== 1'b0 || fif.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_wb: wb_valid=%b busy=%b required 0 0", fif.wb_valid, fif.busy);
    end
  endtask

  task automatic test_timeout();
    go_exec(4'd2, 4'd2, 4'd3); // now in EXEC cycle 1
`ifdef FUST_M_ISSUE_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (fif.timeout_err !== 1'b0 || fif.busy !== 1'b1) begin
        errors++;
        $display("FAIL tmo_early_%0d: timeout_err=%b busy=%b required 0 1", k,
                 fif.timeout_err, fif.busy);
      end
      step();
    end
    checks++;
    if (fif.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire: timeout_err=%b required 1", fif.timeout_err);
    end
    step();
    checks++;
    if (fif.busy !== 1'b0 || fif.timeout_err !== 1'b0 || fif.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: busy=%b tmo=%b wb_valid=%b required 0 0 0", fif.busy,
               fif.timeout_err, fif.wb_valid);
    end
`else
    for (int k = 1; k <= 20; k++) step();
    checks++;
    if (fif.timeout_err !== 1'b0 || fif.busy !== 1'b1) begin
      errors++;
      $display("FAIL no_tmo: timeout_err=%b busy=%b required 0 1", fif.timeout_err, fif.busy);
    end
    fif.mu_done = 1'b1;
    step();
    fif.mu_done = 1'b0; fif.wb_ack = 1'b1;
    checks++;
    if (fif.wb_valid !== 1'b1 || fif.wb_rd !== 4'd3) begin
      errors++;
      $display("FAIL no_tmo_wb: wb_valid=%b wb_rd=%0d required 1 3", fif.wb_valid, fif.wb_rd);
    end
    step();
    fif.wb_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_operand_stall();
    test_grant_stall();
    test_back_to_back();
    test_flush();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
